// File: rtl/disp_pkg.sv
// Shared constants and the leading-zero blanking rule for the 4-digit scan controller.
package disp_pkg;

    localparam int DIGITS = 4;
    localparam int SCAN_W = 2;
    localparam int NIB_W  = 4;
    localparam int HEXS_W = 16;

    // Digit idx is a leading zero when it and every digit to its left are zero;
    // digit 0 is always shown so the value zero still displays one "0".
    function automatic logic lz_blank(input logic [HEXS_W-1:0] hexs,
                                      input logic [SCAN_W-1:0] idx);
        logic all_zero;
        all_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (i >= int'(idx) && hexs[i*NIB_W +: NIB_W] != '0)
                all_zero = 1'b0;
        end
        return (idx != '0) && all_zero;
    endfunction

endpackage

// File: rtl/disp_prescaler.sv
// Digit-slot prescaler: counts DIV clocks per slot, flags the last clock and the dead time.
module disp_prescaler #(
    parameter int DIV   = 50000,
    parameter int DEAD  = 16,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic slot_end,
    output logic dead
);

    localparam logic [CNT_W-1:0] LAST   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_C = CNT_W'(DEAD);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    assign slot_end = en && (cnt == LAST);
    assign dead     = (cnt < DEAD_C);

endmodule

// File: rtl/disp_scan_ctrl.sv
// Scan sequencer for dispsync: digit index, dead time, frame-aligned double buffer and blank request.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int DEAD  = 16,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [HEXS_W-1:0] hexs_in,
    input  logic              hexs_wr,
    input  logic [DIGITS-1:0] blank_mask,
    input  logic              lz_suppress,
    output logic [SCAN_W-1:0] scan,
    output logic [HEXS_W-1:0] hexs_q,
    output logic              blank,
    output logic              frame_tick,
    output logic              upd_pending
);

    logic              slot_end;
    logic              dead;
    logic              boundary;
    logic [HEXS_W-1:0] pend;

    disp_prescaler #(
        .DIV   (DIV),
        .DEAD  (DEAD),
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .slot_end (slot_end),
        .dead     (dead)
    );

    assign boundary = slot_end && (scan == SCAN_W'(DIGITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan        <= '0;
            hexs_q      <= '0;
            pend        <= '0;
            upd_pending <= 1'b0;
            frame_tick  <= 1'b0;
        end else begin
            frame_tick <= boundary;
            if (slot_end)
                scan <= scan + 1'b1;
            // A same-cycle write lands in pend while the previous pend goes on display.
            if (boundary && upd_pending)
                hexs_q <= pend;
            if (hexs_wr) begin
                pend        <= hexs_in;
                upd_pending <= 1'b1;
            end else if (boundary) begin
                upd_pending <= 1'b0;
            end
        end
    end

    // Decoded only from registers and static controls, so it never glitches against scan.
    assign blank = !en || dead || blank_mask[scan] || (lz_suppress && lz_blank(hexs_q, scan));

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed and randomized bench for disp_scan_ctrl against a frame-position reference model.
module tb_disp_scan_ctrl;

    localparam int DIV   = 8;
    localparam int DEAD  = 2;
    localparam int CNT_W = 3;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] hexs_in;
    logic        hexs_wr;
    logic [3:0]  blank_mask;
    logic        lz_suppress;
    logic [1:0]  scan;
    logic [15:0] hexs_q;
    logic        blank;
    logic        frame_tick;
    logic        upd_pending;

    int n_cmp = 0;
    int n_err = 0;
    int tick_cnt = 0;

    // Model: t is the position inside the frame in enabled clocks.
    int          t;
    logic [15:0] m_q;
    logic [15:0] m_pend;
    logic        m_pending;
    logic        m_tick;

    disp_scan_ctrl #(.DIV(DIV), .DEAD(DEAD), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .hexs_in     (hexs_in),
        .hexs_wr     (hexs_wr),
        .blank_mask  (blank_mask),
        .lz_suppress (lz_suppress),
        .scan        (scan),
        .hexs_q      (hexs_q),
        .blank       (blank),
        .frame_tick  (frame_tick),
        .upd_pending (upd_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_blank();
        int digit;
        digit = t / DIV;
        if (!en) return 1'b1;
        if (t % DIV < DEAD) return 1'b1;
        if (blank_mask[digit]) return 1'b1;
        if (lz_suppress && digit != 0 && (m_q >> (4 * digit)) == 16'h0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        t = 0; m_q = '0; m_pend = '0; m_pending = 1'b0; m_tick = 1'b0;
    endtask

    // One clock: compare at the falling edge, advance the model, step past the rising edge.
    task automatic cycle();
        logic bnd;
        @(negedge clk);
        check("scan", 32'(scan), 32'(t / DIV));
        check("blank", 32'(blank), 32'(exp_blank()));
        check("hexs_q", 32'(hexs_q), 32'(m_q));
        check("frame_tick", 32'(frame_tick), 32'(m_tick));
        check("upd_pending", 32'(upd_pending), 32'(m_pending));
        if (frame_tick) tick_cnt++;
        if (rst) begin
            model_reset();
        end else begin
            bnd    = en && (t == FRAME - 1);
            m_tick = bnd;
            if (bnd && m_pending) m_q = m_pend;
            if (hexs_wr) begin
                m_pend = hexs_in; m_pending = 1'b1;
            end else if (bnd) begin
                m_pending = 1'b0;
            end
            if (en) t = (t + 1) % FRAME;
        end
        @(posedge clk);
        #1;
        hexs_wr = 1'b0;
    endtask

    task automatic run_to(input int target);
        for (int k = 0; k < 4 * FRAME && t != target; k++) cycle();
        check("run_to_reached", 32'(t), 32'(target));
    endtask

    task automatic write(input logic [15:0] v);
        hexs_in = v; hexs_wr = 1'b1;
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_scan", 32'(scan), 32'd0);
        check("rst_blank", 32'(blank), 32'd1);
        check("rst_hexs_q", 32'(hexs_q), 32'h0);
        check("rst_upd_pending", 32'(upd_pending), 32'd0);
        check("rst_frame_tick", 32'(frame_tick), 32'd0);
    endtask

    initial begin
        en = 1'b1; hexs_in = '0; hexs_wr = 1'b0; blank_mask = '0; lz_suppress = 1'b0;
        do_reset();
        cycle(); cycle();
        rst = 1'b0;

        // 1: run, load a value, reset mid-frame, then confirm one tick per frame
        write(16'h5A5A);
        repeat (40) cycle();
        check("pre_reset_q", 32'(hexs_q), 32'h5A5A);
        run_to(13);
        do_reset();
        cycle(); cycle();
        rst = 1'b0;
        cycle();
        tick_cnt = 0;
        repeat (64) cycle();
        check("ticks_in_64", 32'(tick_cnt), 32'd2);

        // 2: write during scan=1, visible at the next scan=0 slot
        run_to(9);
        write(16'hC639);
        check("t2_pending", 32'(upd_pending), 32'd1);
        check("t2_q_held", 32'(hexs_q), 32'h0);
        run_to(0);
        check("t2_q", 32'(hexs_q), 32'hC639);
        check("t2_tick", 32'(frame_tick), 32'd1);
        check("t2_cleared", 32'(upd_pending), 32'd0);

        // 3: last write before the boundary wins
        run_to(4);
        write(16'h1111);
        repeat (5) cycle();
        write(16'h2222);
        run_to(0);
        check("t3_q", 32'(hexs_q), 32'h2222);

        // 4: write in the boundary cycle while another value is pending
        run_to(2);
        write(16'h1234);
        run_to(FRAME - 1);
        write(16'hABCD);
        check("t4_q_old", 32'(hexs_q), 32'h1234);
        check("t4_still_pending", 32'(upd_pending), 32'd1);
        cycle();
        run_to(0);
        check("t4_q_new", 32'(hexs_q), 32'hABCD);

        // 5: leading-zero suppression and mask
        lz_suppress = 1'b1;
        write(16'h0050);
        run_to(0);
        run_to(26); check("t5_d3_blank", 32'(blank), 32'd1);
        run_to(2);  check("t5_d0_shown", 32'(blank), 32'd0);
        run_to(10); check("t5_d1_shown", 32'(blank), 32'd0);
        run_to(18); check("t5_d2_blank", 32'(blank), 32'd1);
        blank_mask = 4'b0010;
        run_to(10); check("t5_mask_d1", 32'(blank), 32'd1);
        blank_mask = 4'b0000;
        write(16'h0000);
        run_to(0);
        run_to(2);  check("t5_zero_d0", 32'(blank), 32'd0);
        run_to(10); check("t5_zero_d1", 32'(blank), 32'd1);
        lz_suppress = 1'b0;

        // 6: freeze at scan=2, cnt=5
        run_to(21);
        en = 1'b0;
        repeat (3) cycle();
        write(16'h7777);
        repeat (6) cycle();
        check("t6_scan_hold", 32'(scan), 32'd2);
        check("t6_blank", 32'(blank), 32'd1);
        check("t6_pending", 32'(upd_pending), 32'd1);
        en = 1'b1;
        repeat (3) cycle();
        check("t6_resume_scan", 32'(scan), 32'd3);
        run_to(0);
        check("t6_q", 32'(hexs_q), 32'h7777);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            en = ($urandom_range(9) != 0);
            if ($urandom_range(15) == 0) begin
                hexs_in = ($urandom_range(1) != 0) ? 16'($urandom) : 16'($urandom_range(255));
                hexs_wr = 1'b1;
            end
            if ($urandom_range(63) == 0) blank_mask = 4'($urandom);
            if ($urandom_range(63) == 0) lz_suppress = 1'($urandom);
            if ($urandom_range(499) == 0) begin
                hexs_wr = 1'b0;
                do_reset();
                cycle();
                rst = 1'b0;
            end else begin
                cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
